// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the digit-serial subtractor: start/ready request,
// operands in, registered result and done pulse out.
interface serial_subtractor_if #(
  parameter int N = 4
) ();
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         ready;
  logic [N-1:0] diff;
  logic         bout;
  logic         done;

  modport master (
    output start, a, b, bin,
    input  ready, diff, bout, done
  );

  modport slave (
    input  start, a, b, bin,
    output ready, diff, bout, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin (mod 2^N) with borrow-out,
// DW bits per cycle, LSB digit first; one-cycle done pulse per result.
module serial_subtractor #(
  parameter int N  = 4,
  parameter int DW = 1
) (
  input  logic              clk,
  input  logic              reset,
  serial_subtractor_if.slave bus
);
  localparam int RUNS = N / DW;
  localparam int CW   = (RUNS > 1) ? $clog2(RUNS) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [N-1:0]  a_sh_q, a_sh_d;
  logic [N-1:0]  b_sh_q, b_sh_d;
  logic [N-1:0]  acc_q, acc_d;
  logic          brw_q, brw_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d;
  logic          done_q, done_d;

  logic [DW:0]   digit;
  logic [DW-1:0] d_dig;
  logic          nb;
  logic [N-1:0]  acc_next;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    done_d  = 1'b0;

    // One digit of a - b - borrow; the extra top bit is the digit's borrow.
    digit    = {1'b0, a_sh_q[DW-1:0]} - {1'b0, b_sh_q[DW-1:0]} - {{DW{1'b0}}, brw_q};
    nb       = digit[DW];
    d_dig    = digit[DW-1:0];
    acc_next = N'({d_dig, acc_q} >> DW);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          brw_d   = bus.bin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d  = acc_next;
        a_sh_d = a_sh_q >> DW;
        b_sh_d = b_sh_q >> DW;
        brw_d  = nb;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(RUNS - 1)) begin
          diff_d  = acc_next;
          bout_d  = nb;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready = (state_q == S_IDLE);
  assign bus.diff  = diff_q;
  assign bus.bout  = bout_q;
  assign bus.done  = done_q;
endmodule
